// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-approach traffic phase controller.
//   state_e  : 3-bit FSM state encoding (value 7 is unused / illegal)
//   L_*      : {R,Y,G} lamp encodings driven onto lights_a / lights_b
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    GREEN_A  = 3'd1,
    YELLOW_A = 3'd2,
    ALLRED_B = 3'd3,
    GREEN_B  = 3'd4,
    YELLOW_B = 3'd5,
    FLASH    = 3'd6
  } state_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: one-cycle enable pulse every TICK_DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for one cycle when the divider reaches TICK_DIV-1
//           (permanently high when TICK_DIV = 1)
module tick_gen
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Decoded straight from the counter so the pulse lines up with the
  // terminal count and is low while reset holds the counter at zero.
  assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-approach traffic-signal controller.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   call_a, call_b      : approach requests (pulse or level), latched
//   flash_en            : level request for flashing-amber mode
//   lights_a, lights_b  : {R,Y,G} lamp drives
//   state               : current FSM state
//   phase_cnt           : ticks elapsed in current state (saturating)
//   tick                : prescaler pulse
//
// state    | meaning
// ---------+----------------------------------------------
// ALLRED_A | clearance before A gets green
// GREEN_A  | A green, B red
// YELLOW_A | A amber, B red
// ALLRED_B | clearance before B gets green
// GREEN_B  | B green, A red
// YELLOW_B | B amber, A red
// FLASH    | maintenance: both approaches blink amber
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = 25000000,
  parameter int CNT_W         = 8,
  parameter int GREEN_MIN     = 10,
  parameter int GREEN_MAX     = 120,
  parameter int YELLOW_T      = 5,
  parameter int ALLRED_T      = 2,
  parameter int REST_IN_GREEN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             call_a,
  input  logic             call_b,
  input  logic             flash_en,
  output logic [2:0]       lights_a,
  output logic [2:0]       lights_b,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam bit               REST     = (REST_IN_GREEN != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ca_q, cb_q, blink_q;
  logic             enter_ga, enter_gb;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALLRED_A: if (flash_en) state_d = FLASH;
                else if (cnt_q == AR_END) state_d = GREEN_A;
      GREEN_A:  if (flash_en || (cb_q && cnt_q >= GMIN_END) ||
                    (cnt_q >= GMAX_END && (!REST || cb_q))) state_d = YELLOW_A;
      YELLOW_A: if (cnt_q == YEL_END) state_d = flash_en ? FLASH : ALLRED_B;
      ALLRED_B: if (flash_en) state_d = FLASH;
                else if (cnt_q == AR_END) state_d = GREEN_B;
      GREEN_B:  if (flash_en || (ca_q && cnt_q >= GMIN_END) ||
                    (cnt_q >= GMAX_END && (!REST || ca_q))) state_d = YELLOW_B;
      YELLOW_B: if (cnt_q == YEL_END) state_d = flash_en ? FLASH : ALLRED_A;
      FLASH:    if (!flash_en) state_d = ALLRED_A;
      default:  state_d = ALLRED_A;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLRED_A;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (state == 3'd7) begin
      // Illegal encoding recovers immediately, without waiting for a tick.
      state_q <= ALLRED_A;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      // Blink starts dark on entry and only toggles while staying in FLASH.
      blink_q <= (state_q == FLASH && state_d == FLASH) ? ~blink_q : 1'b0;
    end
  end

  assign enter_ga = tick && (state_q != GREEN_A) && (state_d == GREEN_A);
  assign enter_gb = tick && (state_q != GREEN_B) && (state_d == GREEN_B);

  // Clearing on green entry takes priority over a coincident new call.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_q <= 1'b0;
      cb_q <= 1'b0;
    end else begin
      ca_q <= enter_ga ? 1'b0 : (ca_q | call_a);
      cb_q <= enter_gb ? 1'b0 : (cb_q | call_b);
    end
  end

  assign phase_cnt = cnt_q;

  always_comb begin
    lights_a = L_RED;
    lights_b = L_RED;
    case (state_q)
      GREEN_A:  lights_a = L_GRN;
      YELLOW_A: lights_a = L_YEL;
      GREEN_B:  lights_b = L_GRN;
      YELLOW_B: lights_b = L_YEL;
      FLASH: begin
        lights_a = {1'b0, blink_q, 1'b0};
        lights_b = {1'b0, blink_q, 1'b0};
      end
      default: begin
        lights_a = L_RED;
        lights_b = L_RED;
      end
    endcase
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised two-approach traffic-signal controller with a programmable tick prescaler, per-phase timing, vehicle/pedestrian call latching with early green termination, optional rest-in-green, and a flashing-amber maintenance mode. It is the board-level successor of the fixed-timing light sequencer. It runs entirely in the `clk` domain using a one-cycle tick enable, with no derived clocks. It drives the LED/relay outputs directly.

## Interface
- `TICK_DIV`, 25000000: `clk` cycles per tick; ≥1.
- `CNT_W`, 8: width of the phase timer.
- `GREEN_MIN`, 10: minimum green in ticks; 1 ≤ `GREEN_MIN` ≤ `GREEN_MAX`.
- `GREEN_MAX`, 120: maximum green in ticks; ≤ 2^`CNT_W`−1.
- `YELLOW_T`, 5: amber duration in ticks; ≥1.
- `ALLRED_T`, 2: all-red clearance in ticks; ≥1.
- `REST_IN_GREEN`, 0: 1 = hold green past `GREEN_MAX` while the opposing call is absent.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `call_a`, in, 1: request for approach A (pulse or level).
- `call_b`, in, 1: request for approach B (pulse or level).
- `flash_en`, in, 1: level; requests flashing-amber mode.
- `lights_a`, out, 3: {R,Y,G} for approach A.
- `lights_b`, out, 3: {R,Y,G} for approach B.
- `state`, out, 3: current FSM state.
- `phase_cnt`, out, `CNT_W`: ticks elapsed in the current state.
- `tick`, out, 1: prescaler pulse.

## Operation
- Prescaler:
  - `div_cnt` counts 0..`TICK_DIV`−1 and wraps.
  - `tick`=1 for exactly one cycle when `div_cnt`==`TICK_DIV`−1.
  - `TICK_DIV`=1 gives `tick` permanently 1.
- States: `ALLRED_A`(0), `GREEN_A`(1), `YELLOW_A`(2), `ALLRED_B`(3), `GREEN_B`(4), `YELLOW_B`(5), `FLASH`(6). Value 7 is illegal and recovers to `ALLRED_A` on the next clock.
- FSM and `phase_cnt` advance only on `tick`. `phase_cnt` clears to 0 on every state change; otherwise it increments, saturating at 2^`CNT_W`−1.
- Call latches `ca_q`/`cb_q`:
  - Set by `call_x` on any cycle.
  - Cleared on the cycle the FSM enters `GREEN_x`. Clear wins over a same-cycle set.
- Transitions, each evaluated at `tick`. Let "end" mean `phase_cnt`==T−1.
  - `ALLRED_A`: if `flash_en` → `FLASH`; else at end of `ALLRED_T` → `GREEN_A`.
  - `GREEN_A` → `YELLOW_A` when any of the following holds:
    - `flash_en`, regardless of timer.
    - `cb_q` and `phase_cnt` ≥ `GREEN_MIN`−1.
    - `phase_cnt` ≥ `GREEN_MAX`−1 and (`REST_IN_GREEN`==0 or `cb_q`).
  - `YELLOW_A`: at end of `YELLOW_T` → `FLASH` if `flash_en`, else → `ALLRED_B`.
  - The B states are symmetric: `ALLRED_B` → `GREEN_B` → `YELLOW_B` → `ALLRED_A`, with `ca_q` as the opposing call.
  - `FLASH`: stay while `flash_en`=1; at a tick with `flash_en`=0 → `ALLRED_A`.
- Lights are a Moore decode of the `state` register, with no extra latency:
  - `GREEN_A`: A=001, B=100.
  - `YELLOW_A`: A=010, B=100.
  - B states mirror the A states.
  - `ALLRED_*`: both 100.
  - `FLASH`: both = {0, `blink`, 0}. `blink` toggles each tick while in `FLASH` and is 0 on entry.
- Reset values:
  - `state`=`ALLRED_A`.
  - `lights_a`=`lights_b`=100.
  - `phase_cnt`=0, `div_cnt`=0, `tick`=0.
  - `ca_q`=`cb_q`=0, `blink`=0.
- Invariant: at no time may both approaches show non-red outside `FLASH`.

## Timing
- A state lasting T ticks spans exactly T·`TICK_DIV` clocks.
- `state` and lights change on the same clock edge on which `tick`=1 and the exit condition holds.
- A call is visible in `cx_q` one clock after `call_x`. It can shorten the current green no earlier than the next tick.
- `flash_en` is sampled only at ticks. Deassertion mid-amber in the approach to `FLASH` still completes the amber, then follows the normal path to `ALLRED`.
- Reset asserted mid-phase: all registers return to their reset values immediately (asynchronous). Operation restarts with a full `ALLRED_T` after release.
- Free-running cycle with no calls and `REST_IN_GREEN`=0: 2·(`ALLRED_T`+`GREEN_MAX`+`YELLOW_T`) ticks.

## Structure
- Package `traffic_pkg`:
  - State enum (3-bit).
  - Light encodings `L_RED`=3'b100, `L_YEL`=3'b010, `L_GRN`=3'b001, `L_OFF`=3'b000.
- Sub-module `tick_gen` (params `TICK_DIV`; ports `clk`, `rst_n`, `tick`). Divider width is `$clog2(TICK_DIV)`, minimum 1.
- Top level contains the call latches, the FSM, the phase timer and the light decode.

## Test plan
Small-parameter build for all scenarios: `TICK_DIV`=4, `GREEN_MIN`=3, `GREEN_MAX`=8, `YELLOW_T`=2, `ALLRED_T`=1.
- Reset, then no calls → `tick` every 4 clocks. Sequence `ALLRED_A`(1)/`GREEN_A`(8)/`YELLOW_A`(2)/`ALLRED_B`(1)/… ticks. Cycle of 22 ticks = 88 clocks.
- `call_b` pulse at tick 2 of `GREEN_A` → `YELLOW_A` at the tick where `phase_cnt`==2 (green = 3 ticks). `cb_q` cleared on entering `GREEN_B`.
- `REST_IN_GREEN`=1, no calls → `GREEN_A` held indefinitely, `phase_cnt` saturates at 255. `call_b` → `YELLOW_A` at the next tick.
- `flash_en`=1 during `GREEN_A` → `YELLOW_A` at the next tick, 2 ticks amber, then `FLASH`. Lights alternate 010/000 on both approaches each tick. `flash_en`=0 → `ALLRED_A`, 100/100.
- `rst_n` low for 1 clock mid-`GREEN_B` → immediate 100/100, `phase_cnt`=0, `state`=`ALLRED_A`.
- Throughout every test, an assertion checks that both approaches are never non-red outside `FLASH`, and that `state`≠7.
